// File: rtl/fp_normalize_round_pkg.sv
// Shared single-precision definitions for the normalize/round/pack stage:
// format constants, flag bit positions and the packed result layout.
package fp_normalize_round_pkg;

  localparam int          FP_BIAS      = 127;
  localparam int          FP_EXP_MAX   = 255;
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  function automatic fp32_t fp_pack(input logic sign, input logic [7:0] exp, input logic [22:0] frac);
    fp32_t r;
    r.sign = sign;
    r.exp  = exp;
    r.frac = frac;
    return r;
  endfunction

endpackage

// File: rtl/fp_normalize_round_lzc.sv
// Parameterized leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W = 48
) (
  input  logic [W-1:0]             a,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int CW = $clog2(W + 1);

  // Scan upward so the highest set bit is the one that sticks.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      cnt = a[i] ? CW'(W - 1 - i) : cnt;
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalize / round-to-nearest-even / pack stage producing an
// IEEE-754 single with {OF, UF, NX} flags behind a valid/ready handshake.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int MANT_W   = 48,
  parameter int EXP_W    = 10,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [2:0]        out_flags
);

  localparam int LZC_W = $clog2(MANT_W + 1);
  localparam int EW    = EXP_W + 2;
  localparam int FW    = MANT_W - 1;
  localparam logic signed [EW-1:0] E_MAX = EW'(FP_EXP_MAX);

  logic [LZC_W-1:0] lzc;
  logic [FW-1:0]    norm;
  logic             s2_adv;
  logic             in_accept;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q,  s1_sign_d;
  logic                 s1_nan_q,   s1_nan_d;
  logic                 s1_inf_q,   s1_inf_d;
  logic                 s1_zero_q,  s1_zero_d;
  logic signed [EW-1:0] s1_exp_q,   s1_exp_d;
  logic [FW-1:0]        s1_frac_q,  s1_frac_d;

  logic        s2_valid_q,   s2_valid_d;
  fp32_t       out_result_q, out_result_d;
  logic [2:0]  out_flags_q,  out_flags_d;

  logic [22:0]          frac;
  logic                 guard;
  logic                 sticky;
  logic                 rnd_up;
  logic [23:0]          frac_inc;
  logic signed [EW-1:0] exp_rnd;
  fp32_t                res;
  logic [2:0]           flags;

  fp_lzc #(.W(MANT_W)) u_lzc (
    .a   (in_mant),
    .cnt (lzc)
  );

  // Stage 1: handshake and normalization; the hidden bit is dropped after the shift.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_adv;
    in_accept  = in_valid && in_ready;
    norm       = FW'(in_mant << lzc);
    s1_valid_d = in_accept || (s1_valid_q && !s2_adv);
    if (in_accept) begin
      s1_sign_d = in_sign;
      s1_nan_d  = in_nan;
      s1_inf_d  = in_inf;
      s1_zero_d = (in_mant == {MANT_W{1'b0}});
      s1_exp_d  = {{2{in_exp[EXP_W-1]}}, in_exp} + EW'(1) - EW'(lzc);
      s1_frac_d = norm;
    end else begin
      s1_sign_d = s1_sign_q;
      s1_nan_d  = s1_nan_q;
      s1_inf_d  = s1_inf_q;
      s1_zero_d = s1_zero_q;
      s1_exp_d  = s1_exp_q;
      s1_frac_d = s1_frac_q;
    end
  end

  // Stage 2: round to nearest even, then resolve special cases by priority.
  always_comb begin
    frac     = s1_frac_q[FW-1 -: 23];
    guard    = s1_frac_q[FW-24];
    sticky   = |s1_frac_q[FW-25:0];
    rnd_up   = ROUND_EN && guard && (sticky || frac[0]);
    frac_inc = {1'b0, frac} + {23'd0, rnd_up};
    exp_rnd  = s1_exp_q + EW'(frac_inc[23]);
    flags    = 3'b000;
    if (s1_nan_q) begin
      res = fp32_t'(FP_CANON_NAN);
    end else if (s1_inf_q) begin
      res = fp_pack(s1_sign_q, 8'hFF, 23'd0);
    end else if (s1_zero_q) begin
      res = fp_pack(s1_sign_q, 8'h00, 23'd0);
    end else if (exp_rnd >= E_MAX) begin
      res            = fp_pack(s1_sign_q, 8'hFF, 23'd0);
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else if (exp_rnd[EW-1] || (exp_rnd == {EW{1'b0}})) begin
      res            = fp_pack(s1_sign_q, 8'h00, 23'd0);
      flags[FLAG_UF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else begin
      res            = fp_pack(s1_sign_q, exp_rnd[7:0], frac_inc[22:0]);
      flags[FLAG_NX] = guard || sticky;
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    if (s2_adv && s1_valid_q) begin
      out_result_d = res;
      out_flags_d  = flags;
    end else begin
      out_result_d = out_result_q;
      out_flags_d  = out_flags_q;
    end
  end

  // Pipeline state; reset drops any in-flight beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_exp_q     <= {EW{1'b0}};
      s1_frac_q    <= {FW{1'b0}};
      s2_valid_q   <= 1'b0;
      out_result_q <= 32'h0000_0000;
      out_flags_q  <= 3'b000;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_nan_q     <= s1_nan_d;
      s1_inf_q     <= s1_inf_d;
      s1_zero_q    <= s1_zero_d;
      s1_exp_q     <= s1_exp_d;
      s1_frac_q    <= s1_frac_d;
      s2_valid_q   <= s2_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule
